// File: rtl/nibble_serial_adder_ctrl.sv
// Iterative WIDTH-bit adder controller driving an external 4-bit adder one nibble per cycle, LSB first.
// Optional build macro OVERFLOW_FLAG_EN adds a registered signed-overflow output 'ovf'.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-5:0]  acc_q;
    logic [WIDTH-1:0]  acc_shift;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic [IDXW-1:0]   idx_q;
    logic              accept;
    logic              last_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        accept     = 1'b0;
        last_nib   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_q[3:0];
                add_b   = b_q[3:0];
                add_cin = carry_q;
                if (idx_q == LAST_IDX) begin
                    last_nib   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands shift right so the active nibble is always at [3:0]; sums enter acc from the top.
    assign acc_shift = {add_sum, acc_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            carry_q <= add_cout;
            idx_q   <= idx_q + IDXW'(1);
            acc_q   <= acc_shift[WIDTH-1:4];
            if (last_nib) begin
                sum_q  <= acc_shift;
                cout_q <= add_cout;
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    // On the last nibble a_q[3]/b_q[3] hold the original operand sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last_nib) begin
            ovf_q <= (a_q[3] == b_q[3]) & (add_sum[3] != a_q[3]);
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl with a behavioural 4-bit adder and arithmetic reference model.
// Build with OVERFLOW_FLAG_EN defined to also check the ovf output.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } result_t;

    result_t sbQueue[$];
    int      checks = 0;
    int      errors = 0;
    bit      randReady = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External 4-bit adder stage, purely combinational.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    function automatic result_t refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic c);
        result_t r;
        longint  total;
        longint  signedTotal;
        total       = longint'(x) + longint'(y) + longint'(c);
        signedTotal = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        r.sum  = total[WIDTH-1:0];
        r.cout = total[WIDTH];
        r.ovf  = (signedTotal > 32767) || (signedTotal < -32768);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Input-side monitor: every accepted operand pair pushes its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sbQueue.push_back(refModel(a, b, cin));
        end
    end

    // Output-side monitor: every result handshake pops and compares.
    always @(negedge clk) begin
        result_t exp;
        if (rst_n && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp = sbQueue.pop_front();
                checkOutput("sb_sum", 32'(sum), 32'(exp.sum));
                checkOutput("sb_cout", 32'(cout), 32'(exp.cout));
`ifdef OVERFLOW_FLAG_EN
                checkOutput("sb_ovf", 32'(ovf), 32'(exp.ovf));
`endif
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Presents an operand pair and returns just after the accepting clock edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        bit ok;
        ok = 1'b0;
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // Runs one op, recording add_a / add_cin across the four RUN cycles and checking latency.
    task automatic runDirected(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                               input logic [15:0] expASeq, input logic [3:0] expCinSeq);
        logic [15:0] aSeq;
        logic [3:0]  cinSeq;
        aSeq   = '0;
        cinSeq = '0;
        applyStimulus(x, y, c);
        for (int k = 0; k < 4; k++) begin
            aSeq   = {aSeq[11:0], add_a};
            cinSeq = {cinSeq[2:0], add_cin};
            if (k == 3) checkOutput("valid_early", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
        checkOutput("add_a_seq", 32'(aSeq), 32'(expASeq));
        checkOutput("add_cin_seq", 32'(cinSeq), 32'(expCinSeq));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        $display("[TB] reset released");
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        @(posedge clk);
        #1;

        runDirected(16'h1234, 16'h4321, 1'b0, 16'h4321, 4'b0000);
        checkOutput("t1_sum", 32'(sum), 32'h5555);
        runDirected(16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 4'b1111);
        checkOutput("t2_sum", 32'(sum), 32'h0000);
        checkOutput("t2_cout", 32'(cout), 32'd1);
        runDirected(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 4'b1111);
        checkOutput("t3_sum", 32'(sum), 32'hFFFF);
        checkOutput("t3_cout", 32'(cout), 32'd1);
        checkOutput("idle_add_a", 32'(add_a), 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'hBEEF, 16'h1357, 1'b1);
        waitOutValid();
        held     = sum;
        a        = 16'h0F0F;
        b        = 16'h00FF;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_sum_stable", 32'(sum), 32'(held));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        applyStimulus(16'h0F0F, 16'h00FF, 1'b0);
        waitOutValid();
        @(posedge clk);
        #1;

        $display("[TB] reset during run");
        applyStimulus(16'hABCD, 16'h5432, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        sbQueue.delete();
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_add_a", 32'(add_a), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_in_ready_rel", 32'(in_ready), 32'd1);
        applyStimulus(16'd1, 16'd1, 1'b0);
        waitOutValid();
        checkOutput("abort_next_sum", 32'(sum), 32'd2);
        @(posedge clk);
        #1;

`ifdef OVERFLOW_FLAG_EN
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        waitOutValid();
        checkOutput("ovf_pos_sum", 32'(sum), 32'h8000);
        checkOutput("ovf_pos", 32'(ovf), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitOutValid();
        checkOutput("ovf_neg", 32'(ovf), 32'd0);
        checkOutput("ovf_neg_cout", 32'(cout), 32'd1);
        @(posedge clk);
        #1;
`endif

        $display("[TB] random traffic");
        randReady = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (sbQueue.size() == 0 && !busy) break;
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        checkOutput("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
